// File: rtl/hour_alarm_if.sv
// Control and display bundle between the hour controller and its host.
// slave = controller side, master = host/driver side.
interface hour_alarm_if;
  logic       mode_12h;
  logic       alarm_en;
  logic [4:0] alarm_hour;
  logic       alarm_ack;
  logic       snooze_req;
  logic [7:0] seg_data_h1;
  logic [7:0] seg_data_h10;
  logic       pm;
  logic       day_tick;
  logic       alarm;
  logic       snoozing;
  logic       missed;

  modport slave (
    input  mode_12h, alarm_en, alarm_hour, alarm_ack, snooze_req,
    output seg_data_h1, seg_data_h10, pm, day_tick, alarm, snoozing, missed
  );

  modport master (
    output mode_12h, alarm_en, alarm_hour, alarm_ack, snooze_req,
    input  seg_data_h1, seg_data_h10, pm, day_tick, alarm, snoozing, missed
  );
endinterface

// File: rtl/hour_alarm_ctrl.sv
// Hour counter (0..23) with 24h/12h seven-segment decode and an hour-granular
// alarm scheduler (ring, snooze, timeout). One clk_h_1 edge per hour.
module hour_alarm_ctrl #(
  parameter int RING_HOURS   = 1,
  parameter int SNOOZE_HOURS = 1,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic         clk_h_1,
  input  logic         rst,
  hour_alarm_if.slave  bus
);
  localparam logic [3:0] RING_LAST   = 4'(RING_HOURS - 1);
  localparam logic [3:0] SNOOZE_INIT = 4'(SNOOZE_HOURS);
  localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  state_t     state_q, state_d;
  logic [4:0] hour_q, hour_d;
  logic [3:0] ring_cnt_q, ring_cnt_d;
  logic [3:0] timer_q, timer_d;
  logic [2:0] snooze_cnt_q, snooze_cnt_d;
  logic       day_tick_q, day_tick_d;
  logic       missed_q, missed_d;
  logic       match;

  always_ff @(posedge clk_h_1 or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      hour_q       <= '0;
      ring_cnt_q   <= '0;
      timer_q      <= '0;
      snooze_cnt_q <= '0;
      day_tick_q   <= 1'b0;
      missed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hour_q       <= hour_d;
      ring_cnt_q   <= ring_cnt_d;
      timer_q      <= timer_d;
      snooze_cnt_q <= snooze_cnt_d;
      day_tick_q   <= day_tick_d;
      missed_q     <= missed_d;
    end
  end

  // Match compares against the hour being entered, so the alarm rises with it.
  always_comb begin
    hour_d       = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
    day_tick_d   = (hour_q == 5'd23);
    match        = bus.alarm_en && (state_q == IDLE) && (hour_d == bus.alarm_hour);
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    timer_d      = timer_q;
    snooze_cnt_d = snooze_cnt_q;
    missed_d     = missed_q;

    if (bus.alarm_ack && (state_q == IDLE))
      missed_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (match) begin
          state_d      = RING;
          ring_cnt_d   = '0;
          snooze_cnt_d = '0;
        end
      end
      RING: begin
        if (!bus.alarm_en || bus.alarm_ack) begin
          state_d = IDLE;
        end else if (bus.snooze_req && (snooze_cnt_q < SNOOZE_MAX)) begin
          state_d      = SNOOZE;
          timer_d      = SNOOZE_INIT;
          snooze_cnt_d = snooze_cnt_q + 3'd1;
        end else if (ring_cnt_q >= RING_LAST) begin
          state_d  = IDLE;
          missed_d = 1'b1;
        end else begin
          ring_cnt_d = ring_cnt_q + 4'd1;
        end
      end
      SNOOZE: begin
        if (!bus.alarm_en || bus.alarm_ack) begin
          state_d = IDLE;
        end else if (timer_q <= 4'd1) begin
          state_d    = RING;
          ring_cnt_d = '0;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  function automatic logic [7:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h27;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  logic [4:0] h12;
  logic [4:0] ones_full;
  logic [3:0] tens;
  logic       tens_blank;

  // 12h shows hour 0/12 as "12" and blanks the tens digit for 1..9.
  always_comb begin
    h12        = (hour_q >= 5'd12) ? hour_q - 5'd12 : hour_q;
    tens       = 4'd0;
    ones_full  = hour_q;
    tens_blank = 1'b0;
    if (bus.mode_12h) begin
      if (h12 == 5'd0) begin
        tens      = 4'd1;
        ones_full = 5'd2;
      end else if (h12 < 5'd10) begin
        tens_blank = 1'b1;
        ones_full  = h12;
      end else begin
        tens      = 4'd1;
        ones_full = h12 - 5'd10;
      end
    end else if (hour_q >= 5'd20) begin
      tens      = 4'd2;
      ones_full = hour_q - 5'd20;
    end else if (hour_q >= 5'd10) begin
      tens      = 4'd1;
      ones_full = hour_q - 5'd10;
    end
  end

  assign bus.seg_data_h1  = seg7(ones_full[3:0]);
  assign bus.seg_data_h10 = tens_blank ? 8'h00 : seg7(tens);
  assign bus.pm           = bus.mode_12h && (hour_q >= 5'd12);
  assign bus.day_tick     = day_tick_q;
  assign bus.alarm        = (state_q == RING);
  assign bus.snoozing     = (state_q == SNOOZE);
  assign bus.missed       = missed_q;
endmodule

// File: tb/tb_hour_alarm_ctrl.sv
// Directed bench for hour_alarm_ctrl: hour count/decode, 12h display, alarm
// match, snooze loop, timeout/missed, async reset and out-of-range alarm hour.
module tb_hour_alarm_ctrl;
  logic clk_h_1;
  logic rst;
  int   err_cnt = 0;
  int   chk_cnt = 0;
  int   tick_no = 0;
  int   hr      = 0;

  hour_alarm_if bus_a();
  hour_alarm_if bus_b();

  hour_alarm_ctrl #(.RING_HOURS(4), .SNOOZE_HOURS(1), .MAX_SNOOZE(3)) dut_a (
    .clk_h_1 (clk_h_1),
    .rst     (rst),
    .bus     (bus_a.slave)
  );

  hour_alarm_ctrl #(.RING_HOURS(2), .SNOOZE_HOURS(1), .MAX_SNOOZE(3)) dut_b (
    .clk_h_1 (clk_h_1),
    .rst     (rst),
    .bus     (bus_b.slave)
  );

  logic [7:0] seg_tbl [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h27, 8'h7F, 8'h6F};
  logic       exp_al [10]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       exp_sn [10]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    clk_h_1 = 1'b0;
    forever #5 clk_h_1 = ~clk_h_1;
  end

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_h_1);
    #1;
    tick_no++;
    hr = (hr + 1) % 24;
    $display("tick %0d hour=%0d h10=%02h h1=%02h day=%b A:al=%b sn=%b ms=%b B:al=%b ms=%b",
             tick_no, hr, bus_a.seg_data_h10, bus_a.seg_data_h1, bus_a.day_tick,
             bus_a.alarm, bus_a.snoozing, bus_a.missed, bus_b.alarm, bus_b.missed);
  endtask

  initial begin
    rst = 1'b1;
    bus_a.mode_12h = 1'b0; bus_a.alarm_en = 1'b0; bus_a.alarm_hour = 5'd0;
    bus_a.alarm_ack = 1'b0; bus_a.snooze_req = 1'b0;
    bus_b.mode_12h = 1'b0; bus_b.alarm_en = 1'b0; bus_b.alarm_hour = 5'd0;
    bus_b.alarm_ack = 1'b0; bus_b.snooze_req = 1'b0;
    #3;
    check_val("rst_h10", bus_a.seg_data_h10, 8'h3F);
    check_val("rst_h1", bus_a.seg_data_h1, 8'h3F);
    check_val("rst_pm", 8'(bus_a.pm), 8'h00);
    check_val("rst_day", 8'(bus_a.day_tick), 8'h00);
    check_val("rst_alarm", 8'(bus_a.alarm), 8'h00);
    check_val("rst_snz", 8'(bus_a.snoozing), 8'h00);
    check_val("rst_missed", 8'(bus_a.missed), 8'h00);
    #9 rst = 1'b0;

    // Full day in 24h mode.
    for (int k = 1; k <= 24; k++) begin
      tick();
      check_val("cnt_h10", bus_a.seg_data_h10, seg_tbl[hr / 10]);
      check_val("cnt_h1", bus_a.seg_data_h1, seg_tbl[hr % 10]);
      check_val("cnt_day", 8'(bus_a.day_tick), (k == 24) ? 8'h01 : 8'h00);
      if (k == 9) begin
        check_val("h09_h10", bus_a.seg_data_h10, 8'h3F);
        check_val("h09_h1", bus_a.seg_data_h1, 8'h6F);
      end
    end

    // 12h display at 00, 12, 13.
    bus_a.mode_12h = 1'b1;
    #1;
    check_val("m12_00_h10", bus_a.seg_data_h10, 8'h06);
    check_val("m12_00_h1", bus_a.seg_data_h1, 8'h5B);
    check_val("m12_00_pm", 8'(bus_a.pm), 8'h00);
    repeat (12) tick();
    check_val("m12_12_h10", bus_a.seg_data_h10, 8'h06);
    check_val("m12_12_h1", bus_a.seg_data_h1, 8'h5B);
    check_val("m12_12_pm", 8'(bus_a.pm), 8'h01);
    tick();
    check_val("m12_13_h10", bus_a.seg_data_h10, 8'h00);
    check_val("m12_13_h1", bus_a.seg_data_h1, 8'h06);
    check_val("m12_13_pm", 8'(bus_a.pm), 8'h01);
    bus_a.mode_12h = 1'b0;
    #1;
    check_val("m24_13_h10", bus_a.seg_data_h10, 8'h06);
    check_val("m24_13_h1", bus_a.seg_data_h1, 8'h4F);
    check_val("m24_13_pm", 8'(bus_a.pm), 8'h00);

    // Alarm at 07, acknowledged one hour later.
    bus_a.alarm_hour = 5'd7;
    bus_a.alarm_en   = 1'b1;
    repeat (17) begin
      tick();
      check_val("pre7_alarm", 8'(bus_a.alarm), 8'h00);
    end
    tick();
    check_val("h7_alarm", 8'(bus_a.alarm), 8'h01);
    check_val("h7_snz", 8'(bus_a.snoozing), 8'h00);
    bus_a.alarm_ack = 1'b1;
    tick();
    check_val("ack_alarm", 8'(bus_a.alarm), 8'h00);
    check_val("ack_missed", 8'(bus_a.missed), 8'h00);
    bus_a.alarm_ack = 1'b0;

    // Snooze loop at 10 with snooze_req held: three snoozes, then timeout.
    bus_a.alarm_hour = 5'd10;
    bus_a.snooze_req = 1'b1;
    tick();
    check_val("pre10_alarm", 8'(bus_a.alarm), 8'h00);
    tick();
    check_val("h10_alarm", 8'(bus_a.alarm), 8'h01);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("snz_alarm", 8'(bus_a.alarm), 8'(exp_al[i]));
      check_val("snz_snz", 8'(bus_a.snoozing), 8'(exp_sn[i]));
      check_val("snz_missed", 8'(bus_a.missed), (i == 9) ? 8'h01 : 8'h00);
    end
    bus_a.snooze_req = 1'b0;
    bus_a.alarm_ack  = 1'b1;
    tick();
    check_val("clr_missed", 8'(bus_a.missed), 8'h00);
    check_val("clr_alarm", 8'(bus_a.alarm), 8'h00);
    bus_a.alarm_ack = 1'b0;
    bus_a.alarm_en  = 1'b0;

    // Timeout with RING_HOURS=2 on the second instance, alarm at 23.
    bus_b.alarm_hour = 5'd23;
    bus_b.alarm_en   = 1'b1;
    tick();
    check_val("b22_alarm", 8'(bus_b.alarm), 8'h00);
    tick();
    check_val("b23_alarm", 8'(bus_b.alarm), 8'h01);
    tick();
    check_val("b00_alarm", 8'(bus_b.alarm), 8'h01);
    check_val("b00_missed", 8'(bus_b.missed), 8'h00);
    check_val("a00_day", 8'(bus_a.day_tick), 8'h01);
    tick();
    check_val("b01_alarm", 8'(bus_b.alarm), 8'h00);
    check_val("b01_missed", 8'(bus_b.missed), 8'h01);
    check_val("a01_day", 8'(bus_a.day_tick), 8'h00);
    bus_b.alarm_ack = 1'b1;
    bus_b.alarm_en  = 1'b0;
    tick();
    check_val("b_clr_missed", 8'(bus_b.missed), 8'h00);
    bus_b.alarm_ack = 1'b0;

    // Asynchronous reset while ringing.
    bus_a.alarm_hour = 5'd3;
    bus_a.alarm_en   = 1'b1;
    tick();
    check_val("h3_alarm", 8'(bus_a.alarm), 8'h01);
    #1 rst = 1'b1;
    #1;
    check_val("arst_alarm", 8'(bus_a.alarm), 8'h00);
    check_val("arst_h10", bus_a.seg_data_h10, 8'h3F);
    check_val("arst_h1", bus_a.seg_data_h1, 8'h3F);
    check_val("arst_snz", 8'(bus_a.snoozing), 8'h00);
    #1 rst = 1'b0;
    hr = 0;

    // Out-of-range alarm hour never rings.
    bus_a.alarm_hour = 5'd25;
    repeat (30) begin
      tick();
      check_val("h25_alarm", 8'(bus_a.alarm), 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
